// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, FSM states and decimal range helper for the 7-segment driver
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;
  localparam logic [6:0] G_DASH = 7'b0111111;
  localparam logic [6:0] G_BLANK = 7'b1111111;
  // Entry n is the active-low GFEDCBA glyph for hex digit n (F listed first).
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000,
    7'b0011000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
  function automatic logic [63:0] max_dec(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: one digit decoder
//   nib   - 4-bit digit value
//   blank - show all segments off
//   dash  - show "-" (takes priority over blank)
//   seg   - active-low GFEDCBA pattern
module seg7_glyph import seg7_pkg::*; (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  assign seg = dash ? G_DASH : blank ? G_BLANK : GLYPHS[nib];
endmodule

// File: rtl/bin_to_seg7_display.sv
// bin_to_seg7_display: binary to N_DIG active-low 7-segment digits, decimal or hex
//   clk, rst_n         - clock, async active-low reset
//   start, value       - conversion request and operand (captured in IDLE)
//   mode, blank_lz     - 0 dec / 1 hex, leading-zero blanking (captured with value)
//   busy, done         - in-flight flag, one-cycle completion pulse
//   overflow, seg      - result did not fit, registered digit patterns (digit 0 in [6:0])
module bin_to_seg7_display import seg7_pkg::*; #(
  parameter int W_IN = 8,
  parameter int N_DIG = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_IN-1:0]    value,
  input  logic               mode,
  input  logic               blank_lz,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [7*N_DIG-1:0] seg
);
  localparam int BW = 4*N_DIG+4;
  localparam int CW = $clog2(W_IN+1);
  localparam logic [63:0] LIMIT = max_dec(N_DIG);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [W_IN-1:0] bin;
  logic [BW-1:0] bcd, adj;
  logic ovf_r, blz_r, seen;
  logic [N_DIG-1:0] blk;
  logic [7*N_DIG-1:0] seg_n;
  logic [63:0] val64;
  assign val64 = 64'(value);
  assign busy = state != IDLE;
  always_comb begin
    nxt = state == IDLE ? (start ? (mode ? OUT : CONV) : IDLE) :
          state == CONV ? (cnt == CW'(1) ? OUT : CONV) : IDLE;
  end
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BW/4; i++) adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  // Digit i>0 blanks while every digit from i upward is zero; digit 0 always shows.
  always_comb begin
    blk = '0;
    seen = 1'b0;
    for (int i = N_DIG-1; i > 0; i--) begin
      seen = seen | (bcd[4*i+:4] != 4'd0);
      blk[i] = blz_r & ~seen & ~ovf_r;
    end
  end
  for (genvar d = 0; d < N_DIG; d++) begin : g_dig
    seg7_glyph u_glyph (.nib(bcd[4*d+:4]), .blank(blk[d]), .dash(ovf_r), .seg(seg_n[7*d+:7]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bin <= '0;
      bcd <= '0;
      ovf_r <= 1'b0;
      blz_r <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      seg <= '1;
    end else begin
      state <= nxt;
      done <= state == OUT;
      if (state == IDLE && start) begin
        cnt <= CW'(W_IN);
        bin <= value;
        bcd <= mode ? BW'(value) : '0;
        ovf_r <= mode ? (val64 >> (4*N_DIG)) != 64'd0 : val64 >= LIMIT;
        blz_r <= blank_lz;
      end else if (state == CONV) begin
        cnt <= cnt - CW'(1);
        {bcd, bin} <= {adj, bin} << 1;
      end else if (state == OUT) begin
        seg <= seg_n;
        overflow <= ovf_r;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_seg7_display.sv
// tb_bin_to_seg7_display: table-driven scoreboard bench for bin_to_seg7_display
module tb_bin_to_seg7_display;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010, G7 = 7'b1111000, G9 = 7'b0011000;
  localparam logic [6:0] GA = 7'b0001000, GB = 7'b0000011, GC = 7'b1000110, GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110, GF = 7'b0001110, BL = 7'b1111111, DS = 7'b0111111;
  typedef struct {
    logic [7:0]  v;
    logic        m;
    logic        b;
    logic [20:0] seg;
    logic        ovf;
    int          lat;
  } tv_t;
  typedef struct {
    logic [20:0] seg;
    logic        ovf;
    int          lat;
    int          acc;
  } sb_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, mode = 1'b0, blz = 1'b0;
  logic [7:0] value = '0;
  logic busy3, done3, ovf3;
  logic [20:0] seg3;
  logic start_b = 1'b0, mode_b = 1'b0, blz_b = 1'b0;
  logic [7:0] value_b = '0;
  logic busy2, done2, ovf2, busy1, done1, ovf1;
  logic [13:0] seg2;
  logic [6:0] seg1;
  int checks = 0, errors = 0, cyc = 0;
  logic [20:0] last_seg = '1;
  sb_t sb[$];
  sb_t mon_e;
  tv_t tv[12];

  bin_to_seg7_display #(.W_IN(8), .N_DIG(3)) dut (.clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .mode(mode), .blank_lz(blz), .busy(busy3), .done(done3), .overflow(ovf3), .seg(seg3));
  bin_to_seg7_display #(.W_IN(8), .N_DIG(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start_b), .value(value_b),
    .mode(mode_b), .blank_lz(blz_b), .busy(busy2), .done(done2), .overflow(ovf2), .seg(seg2));
  bin_to_seg7_display #(.W_IN(8), .N_DIG(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start_b), .value(value_b),
    .mode(mode_b), .blank_lz(blz_b), .busy(busy1), .done(done1), .overflow(ovf1), .seg(seg1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done3 === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done3_unexpected: got done with empty scoreboard, seg=%0h (cycle %0d)", seg3, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("seg3", 64'(seg3), 64'(mon_e.seg));
        chk("ovf3", 64'(ovf3), 64'(mon_e.ovf));
        chk("lat3", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        chk("busy3_low_at_done", 64'(busy3), 64'd0);
        last_seg = mon_e.seg;
      end
    end
  end

  task automatic wait_done3();
    int n;
    n = 0;
    while (done3 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done3_within_budget", 64'(n < 40), 64'd1);
  endtask

  task automatic conv3(input tv_t t, input bit poke);
    @(negedge clk);
    value = t.v;
    mode = t.m;
    blz = t.b;
    start = 1'b1;
    sb.push_back('{seg: t.seg, ovf: t.ovf, lat: t.lat, acc: cyc + 1});
    @(negedge clk);
    start = 1'b0;
    value = 8'($urandom);
    mode = ~t.m;
    blz = ~t.b;
    chk("busy3_after_start", 64'(busy3), 64'd1);
    if (poke) begin
      repeat (2) @(negedge clk);
      chk("seg3_hold_mid_conv", 64'(seg3), 64'(last_seg));
      value = 8'd0;
      mode = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done3();
  endtask

  task automatic convb(input logic [7:0] v, input logic m, input logic b,
                       input logic [13:0] e2, input logic o2, input logic [6:0] e1, input logic o1);
    int n;
    @(negedge clk);
    value_b = v;
    mode_b = m;
    blz_b = b;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done2_within_budget", 64'(n < 40), 64'd1);
    chk("seg2", 64'(seg2), 64'(e2));
    chk("ovf2", 64'(ovf2), 64'(o2));
    chk("done1", 64'(done1), 64'd1);
    chk("seg1", 64'(seg1), 64'(e1));
    chk("ovf1", 64'(ovf1), 64'(o1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{8'd31,  1'b0, 1'b1, {BL, G3, G1}, 1'b0, 9};
    tv[1]  = '{8'd0,   1'b0, 1'b1, {BL, BL, G0}, 1'b0, 9};
    tv[2]  = '{8'd0,   1'b0, 1'b0, {G0, G0, G0}, 1'b0, 9};
    tv[3]  = '{8'd255, 1'b0, 1'b0, {G2, G5, G5}, 1'b0, 9};
    tv[4]  = '{8'hA5,  1'b1, 1'b0, {G0, GA, G5}, 1'b0, 1};
    tv[5]  = '{8'd100, 1'b0, 1'b1, {G1, G0, G0}, 1'b0, 9};
    tv[6]  = '{8'h07,  1'b1, 1'b1, {BL, BL, G7}, 1'b0, 1};
    tv[7]  = '{8'h0F,  1'b1, 1'b0, {G0, G0, GF}, 1'b0, 1};
    tv[8]  = '{8'd205, 1'b0, 1'b1, {G2, G0, G5}, 1'b0, 9};
    tv[9]  = '{8'd9,   1'b0, 1'b0, {G0, G0, G9}, 1'b0, 9};
    tv[10] = '{8'hB0,  1'b1, 1'b1, {BL, GB, G0}, 1'b0, 1};
    tv[11] = '{8'hDE,  1'b1, 1'b1, {BL, GD, GE}, 1'b0, 1};
    repeat (3) @(negedge clk);
    chk("rst_seg3", 64'(seg3), 64'h1FFFFF);
    chk("rst_busy3", 64'(busy3), 64'd0);
    chk("rst_done3", 64'(done3), 64'd0);
    chk("rst_ovf3", 64'(ovf3), 64'd0);
    chk("rst_seg2", 64'(seg2), 64'h3FFF);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) conv3(tv[i], i == 3);
    repeat (3) @(negedge clk);
    chk("seg3_hold_idle", 64'(seg3), 64'(last_seg));
    // start held high: accepted, done, re-accepted on the edge after done
    @(negedge clk);
    value = 8'h3C;
    mode = 1'b1;
    blz = 1'b0;
    start = 1'b1;
    sb.push_back('{seg: {G0, G3, GC}, ovf: 1'b0, lat: 1, acc: cyc + 1});
    sb.push_back('{seg: {G0, G3, GC}, ovf: 1'b0, lat: 1, acc: cyc + 3});
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_sb_drained", 64'(sb.size()), 64'd0);
    // reset in the middle of a decimal conversion
    @(negedge clk);
    value = 8'd200;
    mode = 1'b0;
    blz = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg3", 64'(seg3), 64'h1FFFFF);
    chk("midrst_busy3", 64'(busy3), 64'd0);
    chk("midrst_done3", 64'(done3), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_seg = '1;
    repeat (12) @(negedge clk);
    chk("postrst_idle", 64'(busy3), 64'd0);
    chk("postrst_seg3", 64'(seg3), 64'h1FFFFF);
    conv3(tv[0], 1'b0);
    // narrower displays: overflow and recovery
    convb(8'd100, 1'b0, 1'b0, {DS, DS}, 1'b1, DS, 1'b1);
    convb(8'd99,  1'b0, 1'b1, {G9, G9}, 1'b0, DS, 1'b1);
    convb(8'h1F,  1'b1, 1'b1, {G1, GF}, 1'b0, DS, 1'b1);
    convb(8'd5,   1'b0, 1'b1, {BL, G5}, 1'b0, G5, 1'b0);
    convb(8'h0C,  1'b1, 1'b0, {G0, GC}, 1'b0, GC, 1'b0);
    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
